// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSB slice first,
// with valid/ready handshakes on the operand and result sides.
module serial_addsub #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             cin,
   input  logic             sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  opA_q, opA_d;
   logic [WIDTH-1:0]  opB_q, opB_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              chainCarry_q, chainCarry_d;
   logic              carryOut_q, carryOut_d;
   logic              overflow_q, overflow_d;
   logic [CW-1:0]     count_q, count_d;

   logic [DIGIT:0]    sliceSum;
   logic              msbCarryIn;
   logic              lastSlice;
   logic              accept;

   assign accept    = (state_q == IDLE) && in_valid;
   assign lastSlice = (count_q == CW'(N - 1));

   // The carry into the slice MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
   always_comb begin
      sliceSum   = {1'b0, opA_q[DIGIT-1:0]} + {1'b0, opB_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, chainCarry_q};
      msbCarryIn = opA_q[DIGIT-1] ^ opB_q[DIGIT-1] ^ sliceSum[DIGIT-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = BUSY;
         BUSY:    if (lastSlice) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Subtraction is folded in at accept time: B is inverted and the borrow becomes ~cin.
   always_comb begin
      opA_d        = opA_q;
      opB_d        = opB_q;
      result_d     = result_q;
      chainCarry_d = chainCarry_q;
      carryOut_d   = carryOut_q;
      overflow_d   = overflow_q;
      count_d      = count_q;
      if (accept) begin
         opA_d        = src1;
         opB_d        = sub ? ~src2 : src2;
         chainCarry_d = sub ? ~cin : cin;
         count_d      = '0;
      end else if (state_q == BUSY) begin
         opA_d        = opA_q >> DIGIT;
         opB_d        = opB_q >> DIGIT;
         result_d     = (result_q >> DIGIT)
                      | (WIDTH'(sliceSum[DIGIT-1:0]) << (WIDTH - DIGIT));
         chainCarry_d = sliceSum[DIGIT];
         count_d      = count_q + CW'(1);
         if (lastSlice) begin
            carryOut_d = sliceSum[DIGIT];
            overflow_d = msbCarryIn ^ sliceSum[DIGIT];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opA_q        <= '0;
         opB_q        <= '0;
         result_q     <= '0;
         chainCarry_q <= 1'b0;
         carryOut_q   <= 1'b0;
         overflow_q   <= 1'b0;
         count_q      <= '0;
      end else begin
         opA_q        <= opA_d;
         opB_q        <= opB_d;
         result_q     <= result_d;
         chainCarry_q <= chainCarry_d;
         carryOut_q   <= carryOut_d;
         overflow_q   <= overflow_d;
         count_q      <= count_d;
      end
   end

   assign sum      = result_q;
   assign carry    = carryOut_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: three serial_addsub instances (32/8, 8/1, 16/16) share one
// stimulus stream and are compared against an arithmetic reference model.
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] src1, src2;
   logic        cin, sub, inValid, outReady;

   logic [31:0] sum32;
   logic        carry32, ovf32, outValid32, inReady32;
   logic [7:0]  sum8;
   logic        carry8, ovf8, outValid8, inReady8;
   logic [15:0] sum16;
   logic        carry16, ovf16, outValid16, inReady16;

   int total = 0;
   int bad   = 0;
   int lat32, lat8, lat16;
   logic [31:0] rSum32;
   logic [7:0]  rSum8;
   logic [15:0] rSum16;
   logic        rCarry32, rOvf32, rCarry8, rCarry16;
   int pulses;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(32), .DIGIT(8)) dutW32 (
      .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .cin(cin), .sub(sub),
      .in_valid(inValid), .in_ready(inReady32), .sum(sum32), .carry(carry32),
      .overflow(ovf32), .out_valid(outValid32), .out_ready(outReady));

   serial_addsub #(.WIDTH(8), .DIGIT(1)) dutW8 (
      .clk(clk), .rst_n(rst_n), .src1(src1[7:0]), .src2(src2[7:0]), .cin(cin), .sub(sub),
      .in_valid(inValid), .in_ready(inReady8), .sum(sum8), .carry(carry8),
      .overflow(ovf8), .out_valid(outValid8), .out_ready(outReady));

   serial_addsub #(.WIDTH(16), .DIGIT(16)) dutW16 (
      .clk(clk), .rst_n(rst_n), .src1(src1[15:0]), .src2(src2[15:0]), .cin(cin), .sub(sub),
      .in_valid(inValid), .in_ready(inReady16), .sum(sum16), .carry(carry16),
      .overflow(ovf16), .out_valid(outValid16), .out_ready(outReady));

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Returns {overflow, carry, sum} for a w-bit operation, using signed-range overflow.
   function automatic logic [63:0] refModel(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic c,
                                            input logic s);
      longint mask, half, ua, ub, c0, full, sa, sb, r;
      logic   ovf;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(a) & mask;
      ub   = longint'(s ? ~b : b) & mask;
      c0   = s ? longint'(!c) : longint'(c);
      full = ua + ub + c0;
      sa   = (ua >= half) ? ua - (mask + 1) : ua;
      sb   = (ub >= half) ? ub - (mask + 1) : ub;
      r    = sa + sb + c0;
      ovf  = (r >= half) || (r < -half);
      return {30'b0, ovf, 1'((full >> w) & 1), 32'(full & mask)};
   endfunction

   // Run one operation on all instances; optionally hold out_ready low while pulsing in_valid.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic c,
                                input logic s, input int hold, input logic pulse);
      logic [63:0] m32, m8, m16;
      m32 = refModel(32, a, b, c, s);
      m8  = refModel(8, a, b, c, s);
      m16 = refModel(16, a, b, c, s);
      src1 = a; src2 = b; cin = c; sub = s; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      src1 = $urandom; src2 = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      lat32 = -1; lat8 = -1; lat16 = -1;
      for (int cyc = 1; cyc <= 40 && (lat32 < 0 || lat8 < 0 || lat16 < 0); cyc++) begin
         @(posedge clk); #1;
         if (outValid32 && lat32 < 0) lat32 = cyc;
         if (outValid8 && lat8 < 0)   lat8  = cyc;
         if (outValid16 && lat16 < 0) lat16 = cyc;
      end
      rSum32 = sum32; rCarry32 = carry32; rOvf32 = ovf32;
      rSum8 = sum8; rCarry8 = carry8; rSum16 = sum16; rCarry16 = carry16;
      checkOutput("lat32", 64'(lat32), 64'd4);
      checkOutput("lat8", 64'(lat8), 64'd8);
      checkOutput("lat16", 64'(lat16), 64'd1);
      checkOutput("sum32", 64'(sum32), 64'(m32[31:0]));
      checkOutput("carry32", 64'(carry32), 64'(m32[32]));
      checkOutput("ovf32", 64'(ovf32), 64'(m32[33]));
      checkOutput("sum8", 64'(sum8), 64'(m8[7:0]));
      checkOutput("carry8", 64'(carry8), 64'(m8[32]));
      checkOutput("ovf8", 64'(ovf8), 64'(m8[33]));
      checkOutput("sum16", 64'(sum16), 64'(m16[15:0]));
      checkOutput("carry16", 64'(carry16), 64'(m16[32]));
      checkOutput("ovf16", 64'(ovf16), 64'(m16[33]));
      for (int i = 0; i < hold; i++) begin
         if (pulse) begin
            inValid = 1'b1; src1 = $urandom; src2 = $urandom;
         end
         @(posedge clk); #1;
         inValid = 1'b0;
         checkOutput("hold sum32", 64'(sum32), 64'(m32[31:0]));
         checkOutput("hold carry32", 64'(carry32), 64'(m32[32]));
         checkOutput("hold ovf32", 64'(ovf32), 64'(m32[33]));
         checkOutput("hold valid32", 64'(outValid32), 64'd1);
         checkOutput("hold ready32", 64'(inReady32), 64'd0);
         checkOutput("hold sum8", 64'(sum8), 64'(m8[7:0]));
         checkOutput("hold sum16", 64'(sum16), 64'(m16[15:0]));
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      checkOutput("post valid32", 64'(outValid32), 64'd0);
      checkOutput("post ready32", 64'(inReady32), 64'd1);
      checkOutput("post ready8", 64'(inReady8 & ~outValid8), 64'd1);
      checkOutput("post ready16", 64'(inReady16 & ~outValid16), 64'd1);
   endtask

   initial begin
      src1 = '0; src2 = '0; cin = 1'b0; sub = 1'b0; inValid = 1'b0; outReady = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset sum32", 64'(sum32), 64'd0);
      checkOutput("reset carry32", 64'(carry32), 64'd0);
      checkOutput("reset ovf32", 64'(ovf32), 64'd0);
      checkOutput("reset valid32", 64'(outValid32), 64'd0);
      checkOutput("reset ready32", 64'(inReady32), 64'd1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
      checkOutput("carryout sum", 64'(rSum32), 64'h0);
      checkOutput("carryout carry", 64'(rCarry32), 64'd1);
      checkOutput("carryout ovf", 64'(rOvf32), 64'd0);

      applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
      checkOutput("posovf sum", 64'(rSum32), 64'h8000_0000);
      checkOutput("posovf carry", 64'(rCarry32), 64'd0);
      checkOutput("posovf ovf", 64'(rOvf32), 64'd1);

      applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 1'b0);
      checkOutput("negovf sum", 64'(rSum32), 64'h0);
      checkOutput("negovf carry", 64'(rCarry32), 64'd1);
      checkOutput("negovf ovf", 64'(rOvf32), 64'd1);

      applyStimulus(32'd5, 32'd7, 1'b0, 1'b1, 0, 1'b0);
      checkOutput("sub5-7 sum", 64'(rSum32), 64'hFFFF_FFFE);
      checkOutput("sub5-7 carry", 64'(rCarry32), 64'd0);
      checkOutput("sub5-7 ovf", 64'(rOvf32), 64'd0);

      applyStimulus(32'd7, 32'd5, 1'b1, 1'b1, 0, 1'b0);
      checkOutput("sub7-5 sum", 64'(rSum32), 64'h1);
      checkOutput("sub7-5 carry", 64'(rCarry32), 64'd1);

      applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 10, 1'b1);

      applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("w8 sum", 64'(rSum8), 64'h01);
      checkOutput("w8 carry", 64'(rCarry8), 64'd1);

      applyStimulus(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 0, 1'b0);
      checkOutput("w16 sum", 64'(rSum16), 64'h5555);
      checkOutput("w16 carry", 64'(rCarry16), 64'd0);

      // Abort an operation with reset during its second BUSY cycle.
      src1 = 32'h1111_1111; src2 = 32'h2222_2222; cin = 1'b0; sub = 1'b0; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checkOutput("abort sum32", 64'(sum32), 64'd0);
      checkOutput("abort carry32", 64'(carry32), 64'd0);
      checkOutput("abort ovf32", 64'(ovf32), 64'd0);
      checkOutput("abort valid32", 64'(outValid32), 64'd0);
      checkOutput("abort ready32", 64'(inReady32), 64'd1);
      checkOutput("abort sum8", 64'(sum8), 64'd0);
      checkOutput("abort valid16", 64'(outValid16), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (outValid32 || outValid8 || outValid16) pulses++;
      end
      checkOutput("abort pulses", 64'(pulses), 64'd0);
      checkOutput("abort idle32", 64'(inReady32), 64'd1);

      for (int n = 0; n < 25; n++) begin
         applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
